// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - two-digit BCD counter with prescaler, load and wrap carry
// Down counting is compiled in only when BCD_COUNTER_DOWN_EN is defined.
module bcd_counter #(
  parameter int CLK_DIV = 50000000,
  parameter int MAX_VAL = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_l,
  input  logic [3:0] load_h,
  output logic [3:0] bcd_l,
  output logic [3:0] bcd_h,
  output logic       carry
);

  localparam int            PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]    MAX_H    = 4'(MAX_VAL / 10);
  localparam logic [3:0]    MAX_L    = 4'(MAX_VAL % 10);

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic          tick;
  logic [7:0]    load_val;
  logic          load_ok;
  logic          at_max;

  logic [3:0]    up_l;
  logic [3:0]    up_h;
  logic          up_c;
  logic [3:0]    step_l;
  logic [3:0]    step_h;
  logic          step_c;

  logic [3:0]    l_nxt;
  logic [3:0]    h_nxt;
  logic          carry_nxt;

  assign tick     = en && (pre == PRE_LAST);
  assign load_val = (8'(load_h) * 8'd10) + 8'(load_l);
  assign load_ok  = (load_l <= 4'd9) && (load_val <= 8'(MAX_VAL));
  assign at_max   = (bcd_h == MAX_H) && (bcd_l == MAX_L);

  always_comb begin
    up_l = bcd_l + 4'd1;
    up_h = bcd_h;
    up_c = 1'b0;
    if (at_max) begin
      up_l = 4'd0;
      up_h = 4'd0;
      up_c = 1'b1;
    end else if (bcd_l == 4'd9) begin
      up_l = 4'd0;
      up_h = bcd_h + 4'd1;
    end
  end

`ifdef BCD_COUNTER_DOWN_EN
  logic [3:0] dn_l;
  logic [3:0] dn_h;
  logic       dn_c;

  // Down from 00 wraps to the terminal value, mirroring the up-count wrap.
  always_comb begin
    dn_l = bcd_l - 4'd1;
    dn_h = bcd_h;
    dn_c = 1'b0;
    if (bcd_l == 4'd0) begin
      if (bcd_h != 4'd0) begin
        dn_l = 4'd9;
        dn_h = bcd_h - 4'd1;
      end else begin
        dn_l = MAX_L;
        dn_h = MAX_H;
        dn_c = 1'b1;
      end
    end
  end

  assign step_l = up_dn ? up_l : dn_l;
  assign step_h = up_dn ? up_h : dn_h;
  assign step_c = up_dn ? up_c : dn_c;
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;

  assign step_l = up_l;
  assign step_h = up_h;
  assign step_c = up_c;
`endif

  // Load wins over a same-cycle tick and always restarts the prescaler,
  // even when the loaded value is rejected.
  always_comb begin
    pre_nxt   = pre;
    l_nxt     = bcd_l;
    h_nxt     = bcd_h;
    carry_nxt = 1'b0;
    if (load) begin
      pre_nxt = '0;
      if (load_ok) begin
        l_nxt = load_l;
        h_nxt = load_h;
      end
    end else if (en) begin
      if (tick) begin
        pre_nxt   = '0;
        l_nxt     = step_l;
        h_nxt     = step_h;
        carry_nxt = step_c;
      end else begin
        pre_nxt = pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      bcd_l <= 4'd0;
      bcd_h <= 4'd0;
      carry <= 1'b0;
    end else begin
      pre   <= pre_nxt;
      bcd_l <= l_nxt;
      bcd_h <= h_nxt;
      carry <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - self-checking bench for bcd_counter
// Behavioural model tracks the count as a plain integer; directed cases pin it.
module tb_bcd_counter;

  localparam int CLK_DIV = 4;
  localparam int MAX_VAL = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_l = 4'd0;
  logic [3:0] load_h = 4'd0;
  logic [3:0] bcd_l;
  logic [3:0] bcd_h;
  logic       carry;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  int m_val   = 0;
  int m_pre   = 0;
  bit m_carry = 1'b0;

  bcd_counter #(.CLK_DIV(CLK_DIV), .MAX_VAL(MAX_VAL)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .up_dn  (up_dn),
    .load   (load),
    .load_l (load_l),
    .load_h (load_h),
    .bcd_l  (bcd_l),
    .bcd_h  (bcd_h),
    .carry  (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_up();
`ifdef BCD_COUNTER_DOWN_EN
    return up_dn;
`else
    return 1'b1;
`endif
  endfunction

  // Model: value is an integer 0..MAX_VAL, prescaler an integer 0..CLK_DIV-1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val   = 0;
      m_pre   = 0;
      m_carry = 1'b0;
    end else begin
      m_carry = 1'b0;
      if (load) begin
        m_pre = 0;
        if (load_l <= 9 && (10 * load_h + load_l) <= MAX_VAL)
          m_val = 10 * load_h + load_l;
      end else if (en) begin
        if (m_pre == CLK_DIV - 1) begin
          m_pre = 0;
          if (model_up()) begin
            m_carry = (m_val == MAX_VAL);
            m_val   = (m_val == MAX_VAL) ? 0 : m_val + 1;
          end else begin
            m_carry = (m_val == 0);
            m_val   = (m_val == 0) ? MAX_VAL : m_val - 1;
          end
        end else begin
          m_pre++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_l", int'(bcd_l), m_val % 10);
      chk("model_h", int'(bcd_h), m_val / 10);
      chk("model_carry", int'(carry), int'(m_carry));
    end
  end

  task automatic do_load(input logic [3:0] h, input logic [3:0] l);
    load_h = h;
    load_l = l;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  function automatic int disp();
    return int'({bcd_h, bcd_l});
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_val", disp(), 'h00);
    chk("reset_carry", int'(carry), 0);
    chk_on = 1'b1;

    en    = 1'b1;
    up_dn = 1'b1;
    rst   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      repeat (3) @(negedge clk);
      chk("step_hold", disp(), ((k - 1) / 10) * 16 + (k - 1) % 10);
      @(negedge clk);
      chk("step", disp(), (k / 10) * 16 + k % 10);
    end

    do_load(4'd2, 4'd3);
    chk("load23", disp(), 'h23);
    repeat (3) @(negedge clk);
    chk("wrap_hold", disp(), 'h23);
    @(negedge clk);
    chk("wrap_val", disp(), 'h00);
    chk("wrap_carry", int'(carry), 1);
    @(negedge clk);
    chk("wrap_carry_end", int'(carry), 0);

    do_load(4'd1, 4'd0);
    repeat (2) @(negedge clk);
    do_load(4'd2, 4'd7);
    chk("bad_load_27", disp(), 'h10);
    repeat (3) @(negedge clk);
    chk("bad_load_pre_cleared", disp(), 'h10);
    @(negedge clk);
    chk("after_bad_load", disp(), 'h11);
    @(negedge clk);
    do_load(4'd0, 4'd12);
    chk("bad_load_l12", disp(), 'h11);
    repeat (3) @(negedge clk);
    chk("bad_load_l12_hold", disp(), 'h11);
    @(negedge clk);
    chk("after_bad_load_l12", disp(), 'h12);

    do_load(4'd0, 4'd5);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("freeze", disp(), 'h05);
    en = 1'b1;
    @(negedge clk);
    chk("resume_hold", disp(), 'h05);
    @(negedge clk);
    chk("resume_tick", disp(), 'h06);

    do_load(4'd1, 4'd5);
    repeat (2) @(negedge clk);
    chk("pre_reset_val", disp(), 'h15);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_val", disp(), 'h00);
    chk("async_reset_carry", int'(carry), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_hold", disp(), 'h00);
    @(negedge clk);
    chk("post_reset_tick", disp(), 'h01);

`ifdef BCD_COUNTER_DOWN_EN
    up_dn = 1'b0;
    do_load(4'd1, 4'd0);
    repeat (4) @(negedge clk);
    chk("down_09", disp(), 'h09);
    repeat (4) @(negedge clk);
    chk("down_08", disp(), 'h08);
    do_load(4'd0, 4'd0);
    repeat (4) @(negedge clk);
    chk("down_wrap", disp(), 'h23);
    chk("down_wrap_carry", int'(carry), 1);
    up_dn = 1'b1;
`endif

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
      load   = ($urandom_range(0, 39) == 0);
      load_h = 4'($urandom_range(0, 3));
      load_l = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
